// File: rtl/out_fm_st_filter_if.sv
// rtl/out_fm_st_filter_if.sv - control, FIFO-side and memory-side signals of the tile-store filter
interface out_fm_st_filter_if #(
  parameter int AW = 16,
  parameter int CW = 16,
  parameter int DW = 32
);
  logic          start;
  logic [CW-1:0] tile_base_n;
  logic [CW-1:0] tile_base_row;
  logic [CW-1:0] tile_base_col;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [DW-1:0] data_from_fifo;
  logic          wr_almost_full;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  modport master (
    output start, tile_base_n, tile_base_row, tile_base_col,
    output fifo_empty, data_from_fifo, wr_almost_full,
    input  fifo_pop, wr_ena, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, tile_base_n, tile_base_row, tile_base_col,
    input  fifo_empty, data_from_fifo, wr_almost_full,
    output fifo_pop, wr_ena, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/out_fm_st_filter.sv
// rtl/out_fm_st_filter.sv - drains one output tile from a FIFO into the feature-map buffer, dropping out-of-map elements
module out_fm_st_filter #(
  parameter int AW = 16,
  parameter int CW = 16,
  parameter int DW = 32,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 16,
  parameter int Tr = 64,
  parameter int Tc = 16
) (
  input logic          clk,
  input logic          rst,
  out_fm_st_filter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_base_n;
  logic [CW-1:0] r_base_row;
  logic [CW-1:0] r_base_col;
  logic [CW-1:0] r_tn;
  logic [CW-1:0] r_tr;
  logic [CW-1:0] r_tc;
  logic          r_wr_ena;
  logic [AW-1:0] r_wr_addr;
  logic          r_busy;
  logic          r_done;

  logic          w_pop;
  logic          w_last_tc;
  logic          w_last_tr;
  logic          w_last_tn;
  logic          w_legal;
  logic [CW:0]   w_n;
  logic [CW:0]   w_row;
  logic [CW:0]   w_col;
  logic [63:0]   w_addr_full;

  assign w_pop = (r_state == RUN) && !bus.fifo_empty && !bus.wr_almost_full;

  assign w_last_tc = (r_tc == CW'(Tc - 1));
  assign w_last_tr = (r_tr == CW'(Tr - 1));
  assign w_last_tn = (r_tn == CW'(Tn - 1));

  // One extra bit so a base near the top of the counter range cannot wrap into the map.
  assign w_n   = {1'b0, r_base_n}   + {1'b0, r_tn};
  assign w_row = {1'b0, r_base_row} + {1'b0, r_tr};
  assign w_col = {1'b0, r_base_col} + {1'b0, r_tc};

  assign w_legal = (w_n < (CW+1)'(N)) && (w_row < (CW+1)'(R)) && (w_col < (CW+1)'(C));

  assign w_addr_full = (64'(w_n) * 64'(R) + 64'(w_row)) * 64'(C) + 64'(w_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base_n   <= '0;
      r_base_row <= '0;
      r_base_col <= '0;
      r_tn       <= '0;
      r_tr       <= '0;
      r_tc       <= '0;
      r_wr_ena   <= 1'b0;
      r_wr_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_ena <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_base_n   <= bus.tile_base_n;
            r_base_row <= bus.tile_base_row;
            r_base_col <= bus.tile_base_col;
            r_tn       <= '0;
            r_tr       <= '0;
            r_tc       <= '0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_pop) begin
            // Address and legality describe the element popped now; its data arrives next cycle.
            r_wr_ena  <= w_legal;
            r_wr_addr <= w_addr_full[AW-1:0];
            if (w_last_tc) begin
              r_tc <= '0;
              if (w_last_tr) begin
                r_tr <= '0;
                if (w_last_tn) begin
                  r_tn    <= '0;
                  r_state <= FLUSH;
                end else begin
                  r_tn <= r_tn + CW'(1);
                end
              end else begin
                r_tr <= r_tr + CW'(1);
              end
            end else begin
              r_tc <= r_tc + CW'(1);
            end
          end
        end
        FLUSH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_pop = w_pop;
  assign bus.wr_ena   = r_wr_ena;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_ena ? bus.data_from_fifo : '0;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_out_fm_st_filter.sv
// tb/tb_out_fm_st_filter.sv - randomized scoreboard bench for the tile-store filter
module tb_out_fm_st_filter;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int N  = 32;
  localparam int R  = 64;
  localparam int C  = 32;
  localparam int TN = 16;
  localparam int TR = 64;
  localparam int TC = 16;
  localparam int TOTAL = TN * TR * TC;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  out_fm_st_filter_if #(.AW(AW), .CW(CW), .DW(DW)) bus ();

  out_fm_st_filter #(
    .AW(AW), .CW(CW), .DW(DW), .N(N), .R(R), .C(C), .Tn(TN), .Tr(TR), .Tc(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            mon_writes = 0;
  logic [AW-1:0] mon_log[0:31];
  logic [AW-1:0] mon_last;
  bit            data_pend = 0;
  logic [DW-1:0] data_val;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO read data appears just after the edge that consumed the pop.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (data_pend) begin
        bus.data_from_fifo = data_val;
        data_pend = 0;
      end else begin
        bus.data_from_fifo = DW'($urandom);
      end
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.wr_ena) begin
        if (mon_writes < 32) mon_log[mon_writes] = bus.wr_addr;
        mon_last = bus.wr_addr;
        mon_writes++;
        if (exp_q.size() == 0) begin
          check("write_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  task automatic run_tile(input int bn, input int br, input int bc, input int empty_pct,
                          input bit throttle_af, input bit poke_start, input int abort_at,
                          input int exp_writes);
    int   k = 0;
    int   cyc = 1;
    int   tn, tr, tc, addr;
    int   af_left = 0;
    int   af_writes = 0;
    bit   af_prev = 0;
    bit   af_new;
    bit   finished = 0;
    logic wr_obs;
    wr_t  e;
    mon_writes = 0;
    @(negedge clk);
    bus.start          = 1'b1;
    bus.tile_base_n    = CW'(bn);
    bus.tile_base_row  = CW'(br);
    bus.tile_base_col  = CW'(bc);
    bus.fifo_empty     = ($urandom_range(99) < empty_pct);
    bus.wr_almost_full = 1'b0;
    #1;
    check("pop_in_start_cycle", bus.fifo_pop, 0);
    while (!finished && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      wr_obs = bus.wr_ena;
      if (cyc == 2) check("busy_in_run", bus.busy, 1);
      if (bus.done) begin
        finished = 1;
        if (empty_pct == 0 && !throttle_af) check("tile_cycles", cyc, TOTAL + 3);
        check("busy_at_done", bus.busy, 0);
        check("pop_count", k, TOTAL);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        repeat (2) @(negedge clk);
        check("write_count", mon_writes, exp_writes);
        check("queue_drained", exp_q.size(), 0);
      end else if (abort_at >= 0 && k == abort_at) begin
        finished = 1;
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        check("abort_pop", bus.fifo_pop, 0);
        check("abort_wr_ena", bus.wr_ena, 0);
        check("abort_wr_addr", bus.wr_addr, 0);
        check("abort_wr_data", bus.wr_data, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        exp_q.delete();
        @(negedge clk);
        check("abort_held_wr_ena", bus.wr_ena, 0);
        rst = 1'b0;
        #1;
        check("abort_idle_pop", bus.fifo_pop, 0);
      end else begin
        if (poke_start && cyc == 500) begin
          bus.start         = 1'b1;
          bus.tile_base_n   = CW'(5);
          bus.tile_base_row = CW'(5);
          bus.tile_base_col = CW'(5);
        end else begin
          bus.start         = 1'b0;
          bus.tile_base_n   = CW'($urandom);
          bus.tile_base_row = CW'($urandom);
          bus.tile_base_col = CW'($urandom);
        end
        af_new = 0;
        if (throttle_af && (cyc == 1000 || cyc == 9000)) af_left = 10;
        if (af_left > 0) begin
          af_new = 1;
          af_left--;
        end
        if (af_new || af_prev) af_writes += int'(wr_obs);
        if (af_prev && !af_new) begin
          check("writes_after_af", af_writes <= 1, 1);
          af_writes = 0;
        end
        af_prev = af_new;
        bus.wr_almost_full = af_new;
        bus.fifo_empty     = ($urandom_range(99) < empty_pct);
        #1;
        if (bus.fifo_empty || bus.wr_almost_full) check("pop_while_blocked", bus.fifo_pop, 0);
        if (bus.fifo_pop) begin
          if (k >= TOTAL) begin
            check("pop_past_tile", k, TOTAL - 1);
          end else begin
            tn = k / (TR * TC);
            tr = (k / TC) % TR;
            tc = k % TC;
            data_val  = DW'($urandom);
            data_pend = 1;
            if (bn + tn < N && br + tr < R && bc + tc < C) begin
              addr   = ((bn + tn) * R + br + tr) * C + bc + tc;
              e.addr = AW'(addr);
              e.data = data_val;
              exp_q.push_back(e);
            end
          end
          k++;
        end
      end
    end
    if (!finished) check("tile_timeout", 0, 1);
    bus.start = 1'b0;
    bus.wr_almost_full = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.tile_base_n    = '0;
    bus.tile_base_row  = '0;
    bus.tile_base_col  = '0;
    bus.fifo_empty     = 1'b1;
    bus.wr_almost_full = 1'b0;
    bus.data_from_fifo = '0;
    repeat (3) @(negedge clk);
    check("reset_pop", bus.fifo_pop, 0);
    check("reset_wr_ena", bus.wr_ena, 0);
    check("reset_wr_addr", bus.wr_addr, 0);
    check("reset_wr_data", bus.wr_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    rst = 1'b0;

    run_tile(0, 0, 0, 0, 0, 1, -1, TOTAL);
    check("interior_first_addr", mon_log[0], 0);
    check("interior_row2_addr", mon_log[16], 32);
    check("interior_last_addr", mon_last, 32751);

    run_tile(0, 0, 24, 0, 0, 0, -1, 8192);
    check("coledge_first_addr", mon_log[0], 24);
    check("coledge_row2_addr", mon_log[8], 56);

    run_tile(0, 40, 20, 15, 1, 0, -1, 4608);

    run_tile(0, 0, 0, 0, 0, 0, 100, 0);

    run_tile(24, 0, 0, 0, 0, 0, -1, 8192);
    check("chedge_first_addr", mon_log[0], 24 * 2048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
